// File: rtl/mdu_if.sv
// Handshake and operand bus between the execute stage and the iterative multiply/divide unit.
interface mdu_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] mdu_in1;
  logic [XLEN-1:0] mdu_in2;
  logic [2:0]      mdu_op;
  logic            mdu_start;
  logic            mdu_flush;
  logic            mdu_ready;
  logic            mdu_valid;
  logic [XLEN-1:0] mdu_out;

  // Core side: drives operands and requests, watches ready/valid/result.
  modport master (
    output mdu_in1, mdu_in2, mdu_op, mdu_start, mdu_flush,
    input  mdu_ready, mdu_valid, mdu_out
  );

  // Unit side.
  modport slave (
    input  mdu_in1, mdu_in2, mdu_op, mdu_start, mdu_flush,
    output mdu_ready, mdu_valid, mdu_out
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per clock, on unsigned magnitudes with the result sign applied at completion.
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;    // multiply: partial product high; divide: remainder
  logic [XLEN-1:0]  lo_q, lo_d;    // multiply: multiplier/product low; divide: dividend/quotient
  logic [XLEN-1:0]  b_q, b_d;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]  out_q, out_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;  // negate the magnitude result at completion

  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  // Decode the incoming request: operand signedness, magnitudes and 1-cycle special cases.
  always_comb begin
    a_signed = (bus.mdu_op == 3'b001) || (bus.mdu_op == 3'b010) ||
               (bus.mdu_op == 3'b100) || (bus.mdu_op == 3'b110);
    b_signed = (bus.mdu_op == 3'b001) || (bus.mdu_op == 3'b100) || (bus.mdu_op == 3'b110);
    a_neg    = a_signed & bus.mdu_in1[XLEN-1];
    b_neg    = b_signed & bus.mdu_in2[XLEN-1];
    mag_a    = a_neg ? -bus.mdu_in1 : bus.mdu_in1;
    mag_b    = b_neg ? -bus.mdu_in2 : bus.mdu_in2;
    div_zero = bus.mdu_op[2] & (bus.mdu_in2 == '0);
    // Signed overflow: most-negative / -1 (DIV and REM only).
    div_ovf  = bus.mdu_op[2] & ~bus.mdu_op[0] & (bus.mdu_in1 == MinVal) & (bus.mdu_in2 == '1);
    if (div_zero) begin
      special_res = bus.mdu_op[1] ? bus.mdu_in1 : '1;
    end else begin
      special_res = bus.mdu_op[1] ? '0 : MinVal;
    end
  end

  logic [XLEN:0]     add_sum, div_shift, div_diff;
  logic [XLEN-1:0]   addend, hi_step, lo_step, div_val, calc_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  // One iteration of the datapath plus the sign-corrected result of that iteration.
  always_comb begin
    addend    = lo_q[0] ? b_q : '0;
    add_sum   = {1'b0, hi_q} + {1'b0, addend};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q[2]) begin
      // Restoring step: keep the subtraction only when it does not borrow.
      if (!div_diff[XLEN]) begin
        hi_step = div_diff[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_step = div_shift[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_step = add_sum[XLEN:1];
      lo_step = {add_sum[0], lo_q[XLEN-1:1]};
    end
    prod     = {hi_step, lo_step};
    prod_fix = neg_q ? -prod : prod;
    div_val  = op_q[1] ? hi_step : lo_step;
    if (op_q[2]) begin
      calc_res = neg_q ? -div_val : div_val;
    end else if (op_q[1:0] == 2'b00) begin
      calc_res = prod_fix[XLEN-1:0];
    end else begin
      calc_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic: acceptance, iteration count-down and flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    op_d    = op_q;
    neg_d   = neg_q;
    out_d   = out_q;
    if (bus.mdu_flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (bus.mdu_start) begin
            op_d  = bus.mdu_op;
            hi_d  = '0;
            lo_d  = mag_a;
            b_d   = mag_b;
            // Remainder takes the dividend's sign; everything else the XOR of both.
            neg_d = (bus.mdu_op[2] & bus.mdu_op[1]) ? a_neg : (a_neg ^ b_neg);
            if (div_zero || div_ovf) begin
              out_d   = special_res;
              state_d = StDone;
            end else begin
              cnt_d   = CNT_W'(XLEN);
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          cnt_d = cnt_q - 1'b1;
          hi_d  = hi_step;
          lo_d  = lo_step;
          if (cnt_q == CNT_W'(1)) begin
            out_d   = calc_res;
            state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end

  assign bus.mdu_ready = (state_q != StCalc);
  assign bus.mdu_valid = (state_q == StDone);
  assign bus.mdu_out   = out_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed RV32M cases with literal results, then random traffic, all
// checked every cycle against a cycle-count/arithmetic reference model.
module tb_mdu_iter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mdu_if #(.XLEN(XLEN)) bus ();

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  // Reference arithmetic straight from the RV32M definitions, using 64-bit integers.
  function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    logic [63:0] r;
    bit ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    case (op)
      3'd0: r = 64'(sa * sb);
      3'd1: begin r = 64'(sa * sb); return r[63:32]; end
      3'd2: begin r = 64'(sa * ub); return r[63:32]; end
      3'd3: begin r = 64'(ua * ub); return r[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffff_ffff;
        if (ovf) return 32'h8000_0000;
        r = 64'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hffff_ffff;
        r = 64'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        r = 64'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        r = 64'(ua % ub);
      end
    endcase
    return r[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !op[0] && (a == 32'h8000_0000) && (b == 32'hffff_ffff);
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'h8000_0000;
      1: return 32'hffff_ffff;
      2: return 32'($urandom % 4);
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  // Timing model: remaining busy cycles, expected valid pulse and expected output register.
  int          m_busy;
  bit          m_valid;
  logic [31:0] m_out, m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 0;
      m_valid <= 1'b0;
      m_out   <= '0;
      m_pend  <= '0;
    end else if (bus.mdu_flush) begin
      m_busy  <= 0;
      m_valid <= 1'b0;
    end else if (m_busy > 0) begin
      m_busy  <= m_busy - 1;
      m_valid <= (m_busy == 1);
      if (m_busy == 1) m_out <= m_pend;
    end else begin
      m_valid <= 1'b0;
      if (bus.mdu_start) begin
        if (is_special(bus.mdu_op, bus.mdu_in1, bus.mdu_in2)) begin
          m_out   <= ref_fn(bus.mdu_op, bus.mdu_in1, bus.mdu_in2);
          m_valid <= 1'b1;
        end else begin
          m_pend <= ref_fn(bus.mdu_op, bus.mdu_in1, bus.mdu_in2);
          m_busy <= XLEN;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", 32'(bus.mdu_ready), 32'(m_busy == 0));
      chk("valid", 32'(bus.mdu_valid), 32'(m_valid));
      chk("out", bus.mdu_out, m_out);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.mdu_op    = op;
    bus.mdu_in1   = a;
    bus.mdu_in2   = b;
    bus.mdu_start = 1'b1;
  endtask

  // Wait for the valid pulse after an issue; operands are scrambled meanwhile and an
  // optional stray start is pulsed in cycle 'junk'. Returns in the valid (DONE) cycle.
  task automatic wait_done(input string name, input logic [31:0] want, input int want_lat,
                           input int junk);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.mdu_start = (lat == junk);
      bus.mdu_in1   = $urandom;
      bus.mdu_in2   = $urandom;
      bus.mdu_op    = 3'($urandom);
    end while (!bus.mdu_valid && lat < 100);
    chk({name, "_valid"}, 32'(bus.mdu_valid), 32'd1);
    chk(name, bus.mdu_out, want);
    chk({name, "_lat"}, 32'(lat), 32'(want_lat));
  endtask

  initial begin
    int seen;
    bus.mdu_in1   = '0;
    bus.mdu_in2   = '0;
    bus.mdu_op    = '0;
    bus.mdu_start = 1'b0;
    bus.mdu_flush = 1'b0;

    #1;
    chk("rst_ready", 32'(bus.mdu_ready), 32'd1);
    chk("rst_valid", 32'(bus.mdu_valid), 32'd0);
    chk("rst_out", bus.mdu_out, 32'd0);
    #6 rst = 1'b0;

    // Pin the reference model itself against hand-computed values.
    chk("model_mul", ref_fn(3'd0, 32'd7, 32'hffff_fffd), 32'hffff_ffeb);
    chk("model_mulhsu", ref_fn(3'd2, 32'hffff_ffff, 32'hffff_ffff), 32'hffff_ffff);
    chk("model_div", ref_fn(3'd4, 32'hffff_fff9, 32'd2), 32'hffff_fffd);
    chk("model_rem", ref_fn(3'd6, 32'hffff_fff9, 32'd2), 32'hffff_ffff);

    @(negedge clk);
    issue(3'd0, 32'd7, 32'hffff_fffd);
    wait_done("mul", 32'hffff_ffeb, 33, 0);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    wait_done("mulh", 32'h4000_0000, 33, 0);
    issue(3'd3, 32'hffff_ffff, 32'hffff_ffff);
    wait_done("mulhu", 32'hffff_fffe, 33, 0);
    issue(3'd2, 32'hffff_ffff, 32'hffff_ffff);
    wait_done("mulhsu", 32'hffff_ffff, 33, 0);

    // Divides issued back-to-back in each DONE cycle.
    issue(3'd4, 32'hffff_fff9, 32'd2);
    wait_done("div", 32'hffff_fffd, 33, 0);
    issue(3'd6, 32'hffff_fff9, 32'd2);
    wait_done("rem", 32'hffff_ffff, 33, 0);
    issue(3'd5, 32'd7, 32'd2);
    wait_done("divu", 32'd3, 33, 0);
    issue(3'd7, 32'd7, 32'd2);
    wait_done("remu", 32'd1, 33, 0);

    // Special cases resolve in one cycle.
    issue(3'd5, 32'd5, 32'd0);
    wait_done("divu_zero", 32'hffff_ffff, 1, 0);
    issue(3'd4, 32'h8000_0000, 32'hffff_ffff);
    wait_done("div_ovf", 32'h8000_0000, 1, 0);
    issue(3'd6, 32'h8000_0000, 32'hffff_ffff);
    wait_done("rem_ovf", 32'd0, 1, 0);
    issue(3'd7, 32'd5, 32'd0);
    wait_done("remu_zero", 32'd5, 1, 0);

    // Flush in cycle 10 of a divide.
    issue(3'd4, 32'd100, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.mdu_start = 1'b0;
    end
    bus.mdu_flush = 1'b1;
    @(negedge clk);
    bus.mdu_flush = 1'b0;
    chk("flush_ready", 32'(bus.mdu_ready), 32'd1);
    chk("flush_valid", 32'(bus.mdu_valid), 32'd0);
    chk("flush_out", bus.mdu_out, 32'd5);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.mdu_valid) seen++;
    end
    chk("flush_no_pulse", 32'(seen), 32'd0);

    // A stray start during CALC must not disturb the running op.
    issue(3'd0, 32'd12345, 32'd678);
    wait_done("mul_stray_start", 32'd8369910, 33, 5);

    // Asynchronous reset in the middle of an operation.
    issue(3'd1, 32'd7, 32'd3);
    repeat (5) begin
      @(negedge clk);
      bus.mdu_start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", 32'(bus.mdu_ready), 32'd1);
    chk("async_rst_valid", 32'(bus.mdu_valid), 32'd0);
    chk("async_rst_out", bus.mdu_out, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Random traffic: starts, flushes and corner operands, checked by the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      bus.mdu_op    = 3'($urandom);
      bus.mdu_in1   = rnd_val();
      bus.mdu_in2   = rnd_val();
      bus.mdu_start = ($urandom % 3 != 0);
      bus.mdu_flush = ($urandom % 40 == 0);
      @(negedge clk);
    end
    bus.mdu_start = 1'b0;
    bus.mdu_flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), parametrised in datapath width.
- Sits beside the combinational ALU in the execute stage. The ALU covers the single-cycle base-ISA ops; this block covers multi-cycle M-extension ops.
- The core drives operands and op on a start pulse and stalls until the result-valid pulse.
- Radix-2 shift-add multiply and restoring divide; one bit per clock.

Parameters:
- XLEN, 32, operand/result width (≥4).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mdu_in1  input  XLEN  operand rs1 (multiplicand/dividend).
- mdu_in2  input  XLEN  operand rs2 (multiplier/divisor).
- mdu_op  input  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- mdu_start  input  1  request; sampled only when mdu_ready=1.
- mdu_flush  input  1  abort current operation (pipeline kill).
- mdu_ready  output  1  block can accept mdu_start this cycle.
- mdu_valid  output  1  one-cycle pulse; mdu_out holds the result of the last accepted op.
- mdu_out  output  XLEN  result register.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, mdu_ready=1, mdu_valid=0, mdu_out=0, internal accumulators/counter=0.
- Reset mid-operation aborts immediately with no valid pulse.

State machine:
- IDLE, ready=1: start=1 latches in1, in2 and op.
  - If op is a special divide case, go to DONE.
  - Otherwise go to CALC with counter=XLEN.
- CALC, ready=0: one iteration per cycle; counter decrements. At counter==1 go to DONE and register the sign-corrected result into mdu_out.
- DONE, ready=1, valid=1 for exactly one cycle.
  - start=1 in DONE is accepted back-to-back, as from IDLE.
  - Otherwise go to IDLE.
- Latency: start in cycle 0 → mdu_valid in cycle XLEN+1. Special cases → mdu_valid in cycle 1.
- mdu_start while ready=0 is ignored; no queuing.
- mdu_flush=1 in any state:
  - Next state is IDLE and mdu_valid is 0 next cycle.
  - mdu_out is unchanged.
  - A simultaneous mdu_start is dropped; flush wins.
- Flush in DONE suppresses nothing already shown: the valid pulse of that cycle stands.

Arithmetic:
- Signed operands (MUL*, DIV, REM per RISC-V) are converted to magnitudes at acceptance; the result sign is applied at completion.
  - MULHSU: in1 is signed, in2 is unsigned.
  - MUL: sign handling is irrelevant; the low half is the same.
- Multiply:
  - Form a 2*XLEN-bit unsigned product of the magnitudes.
  - Negate the full 2*XLEN product if the signs differ.
  - MUL returns bits [XLEN-1:0]; MULH, MULHSU and MULHU return [2*XLEN-1:XLEN].
- Divide (restoring), magnitudes:
  - Quotient sign is sign(in1) XOR sign(in2).
  - Remainder sign is sign(in1); the remainder has the dividend's sign.
- Special cases, resolved at acceptance, 1-cycle latency:
  - Divisor=0: DIV and DIVU return all ones; REM and REMU return in1.
  - DIV with in1=-2^(XLEN-1) and in2=-1 returns -2^(XLEN-1); REM returns 0.
- All results are truncated to XLEN; no exceptions or flags are raised.
- Operand inputs may change after acceptance with no effect on the result.

Test Plan:
- Reset-to-idle: rst pulsed asynchronously mid-cycle → mdu_ready=1, mdu_valid=0 and mdu_out=0 immediately, with no clock edge needed.
- MUL, XLEN=32: MUL 7 × 0xFFFFFFFD (−3) → mdu_out=0xFFFFFFEB, valid in cycle 33, ready low in cycles 1–32.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 7/2 → 3; REMU 7/2 → 1. Each op is issued in the DONE cycle of the previous one and completes back-to-back.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF, valid in cycle 1; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Flush and ignored start:
  - mdu_flush in cycle 10 of a DIV → no valid pulse, mdu_out keeps its prior value, ready=1 in cycle 11.
  - A start asserted during CALC is ignored, with the result matching the first op.
